// File: rtl/local_inject_arbiter_if.sv
// Handshake bundle between the packet injectors, the local-port arbiter and the router Local port.
// The master modport is the arbiter's view; the slave modport is the injector/router side.
interface local_inject_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int dataWidth = 32
);
  logic [NUM_REQ-1:0]           ReqUpStr;
  logic [NUM_REQ*dataWidth-1:0] PacketIn;
  logic [NUM_REQ-1:0]           GntUpStr;
  logic [NUM_REQ-1:0]           FullUpStr;
  logic                         ReqDnStr;
  logic                         GntDnStr;
  logic                         DnStrFull;
  logic [dataWidth-1:0]         PacketOut;
  logic [IDX_W-1:0]             GrantIdx;

  modport master (
    input  ReqUpStr, PacketIn, GntDnStr, DnStrFull,
    output GntUpStr, FullUpStr, ReqDnStr, PacketOut, GrantIdx
  );

  modport slave (
    output ReqUpStr, PacketIn, GntDnStr, DnStrFull,
    input  GntUpStr, FullUpStr, ReqDnStr, PacketOut, GrantIdx
  );
endinterface

// File: rtl/local_inject_arbiter.sv
// Round-robin arbiter/sequencer sharing one router Local port among NUM_REQ injectors.
// Optional per-requester grant counters with StatSel/StatCount ports: define LOCAL_ARB_STATS_EN.
module local_inject_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int dataWidth = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  local_inject_arbiter_if.master bus
`ifdef LOCAL_ARB_STATS_EN
  ,
  input  logic [IDX_W-1:0]       StatSel,
  output logic [15:0]            StatCount
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, RELEASE} stateT;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  stateT                stateReg;
  logic [IDX_W-1:0]     lastReg;
  logic [IDX_W-1:0]     grantIdxReg;
  logic                 reqDnReg;
  logic [NUM_REQ-1:0]   gntUpReg;
  logic [dataWidth-1:0] packetReg;

  logic [IDX_W-1:0]     winner;
  logic                 found;
  int                   cand;
  logic [dataWidth-1:0] slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gSlice
      assign slice[gi] = bus.PacketIn[gi*dataWidth +: dataWidth];
    end
  endgenerate

  // Search starts just after the last winner, so every requester gets a turn.
  always_comb begin
    winner = lastReg;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(lastReg) + k) % NUM_REQ;
      if (!found && bus.ReqUpStr[cand]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      lastReg     <= LAST_IDX;
      grantIdxReg <= LAST_IDX;
      reqDnReg    <= 1'b0;
      gntUpReg    <= '0;
      packetReg   <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (found && !bus.DnStrFull) begin
            packetReg   <= slice[winner];
            grantIdxReg <= winner;
            reqDnReg    <= 1'b1;
            stateReg    <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          // Once issued, the request stays up even if the router fills meanwhile.
          if (bus.GntDnStr) begin
            reqDnReg <= 1'b0;
            gntUpReg <= NUM_REQ'(1) << grantIdxReg;
            lastReg  <= grantIdxReg;
            stateReg <= RELEASE;
          end
        end
        RELEASE: begin
          gntUpReg <= '0;
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign bus.ReqDnStr  = reqDnReg;
  assign bus.GntUpStr  = gntUpReg;
  assign bus.PacketOut = packetReg;
  assign bus.GrantIdx  = grantIdxReg;
  assign bus.FullUpStr = {NUM_REQ{bus.DnStrFull}};

`ifdef LOCAL_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] countFlat;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gStat
      logic [15:0] countReg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          countReg <= '0;
        end else if (gntUpReg[gi]) begin
          countReg <= countReg + 16'd1;
        end
      end
      assign countFlat[gi*16 +: 16] = countReg;
    end
  endgenerate

  // Unpopulated selector codes read as zero rather than aliasing a real counter.
  assign StatCount = (int'(StatSel) < NUM_REQ) ? countFlat[int'(StatSel)*16 +: 16] : 16'd0;
`endif

endmodule
